// File: rtl/icache_pkg.sv
// icache_pkg: shared state type, line geometry and address helpers for the i-cache
// refill path. `ADDR_WIDTH normally comes from riscv_core.svh; a 32-bit fallback is
// provided so the refill block also builds standalone.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package icache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StFill,
    StWait,
    StDrain
  } refill_state_t;

  localparam int unsigned LINE_SIZE_DEFAULT = 2;
  localparam int unsigned LINE_BYTES        = 4 * LINE_SIZE_DEFAULT;
  localparam int unsigned OFFSET_BITS       = 2 + $clog2(LINE_SIZE_DEFAULT);

  // Clear the byte-in-line offset bits of an address.
  function automatic logic [`ADDR_WIDTH-1:0] line_align(
    input logic [`ADDR_WIDTH-1:0] addr,
    input int unsigned            offset_bits = OFFSET_BITS
  );
    logic [`ADDR_WIDTH-1:0] mask;
    mask = '1;
    mask = mask << offset_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// icache_line_assembler: collects LINE_SIZE response beats into one cache line.
// Word i of the line lands in bits [32i +: 32]; done flags the beat completing the line.
module icache_line_assembler #(
  parameter int unsigned LINE_SIZE = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      beat_valid,
  input  logic [31:0]               data,
  output logic                      done,
  output logic [32*LINE_SIZE-1:0]   line
);

  localparam int unsigned CntW = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;

  logic [CntW-1:0] cnt_q;

  assign done = beat_valid && (cnt_q == CntW'(LINE_SIZE - 1));

  // Beat counter and word storage; clear only rewinds the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      line  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (beat_valid) begin
      line[32*cnt_q +: 32] <= data;
      cnt_q                <= done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss capture and line refill sequencer for the two-port i-cache.
// Optional feature: define ICACHE_NEXT_LINE_PREFETCH_EN to fetch the next sequential
// line after the last demand line of each miss episode.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINE_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              miss,
  input  logic [`ADDR_WIDTH-1:0]  miss_addr [2],
  input  logic                    ext_flush,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [`ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [31:0]             mem_resp_data,
  output logic                    fill_valid,
  output logic [`ADDR_WIDTH-1:0]  fill_addr,
  output logic [32*LINE_SIZE-1:0] fill_data,
  output logic                    busy
);

  localparam int unsigned Aw      = `ADDR_WIDTH;
  localparam int unsigned OffBits = 2 + $clog2(LINE_SIZE);

  refill_state_t   state_q, state_d;
  logic [Aw-1:0]   pend_addr_q [2];
  logic [Aw-1:0]   pend_addr_d [2];
  logic [1:0]      pend_cnt_q, pend_cnt_d;
  logic            drop_q, drop_d;        // flushed while a request was still unaccepted
  logic            wait_cnt_q, wait_cnt_d;
  logic            req_valid_q, req_valid_d;
  logic [Aw-1:0]   req_addr_q, req_addr_d;
  logic            fill_valid_q, fill_valid_d;
  logic [Aw-1:0]   fill_addr_q, fill_addr_d;
  logic            busy_q, busy_d;
  logic [Aw-1:0]   line0, line1;
  logic            hs;
  logic            asm_clear, asm_beat, asm_done;
  logic [32*LINE_SIZE-1:0] asm_line;

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  localparam logic [Aw-1:0] LineBytesA = Aw'(4 * LINE_SIZE);
  logic            pf_head_q, pf_head_d;  // head entry is the prefetch line
  logic            ff_vld_q, ff_vld_d;    // first line filled this episode is recorded
  logic [Aw-1:0]   ff_addr_q, ff_addr_d;
  logic [Aw-1:0]   pf_line;
  assign pf_line = pend_addr_q[0] + LineBytesA;
`endif

  assign line0    = line_align(miss_addr[0], OffBits);
  assign line1    = line_align(miss_addr[1], OffBits);
  assign hs       = req_valid_q && mem_req_ready;
  assign asm_beat = mem_resp_valid && ((state_q == StResp) || (state_q == StDrain));

  icache_line_assembler #(
    .LINE_SIZE(LINE_SIZE)
  ) u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .beat_valid(asm_beat),
    .data      (mem_resp_data),
    .done      (asm_done),
    .line      (asm_line)
  );

  // Next-state, pending-list maintenance and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    pend_cnt_d   = pend_cnt_q;
    drop_d       = drop_q;
    wait_cnt_d   = wait_cnt_q;
    asm_clear    = 1'b0;
    req_addr_d   = req_addr_q;
    fill_addr_d  = fill_addr_q;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    pf_head_d    = pf_head_q;
    ff_vld_d     = ff_vld_q;
    ff_addr_d    = ff_addr_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        pf_head_d = 1'b0;
        ff_vld_d  = 1'b0;
`endif
        if (!ext_flush && (miss[0] || miss[1])) begin
          if (miss[0]) begin
            pend_addr_d[0] = line0;
            if (miss[1] && (line1 != line0)) begin
              pend_addr_d[1] = line1;
              pend_cnt_d     = 2'd2;
            end else begin
              pend_cnt_d     = 2'd1;
            end
          end else begin
            pend_addr_d[0] = line1;
            pend_cnt_d     = 2'd1;
          end
          state_d = StReq;
        end
      end

      StReq: begin
        // The request stays up until accepted even if a flush arrives meanwhile.
        if (hs) begin
          asm_clear = 1'b1;
          drop_d    = 1'b0;
          state_d   = (drop_q || ext_flush) ? StDrain : StResp;
        end else if (ext_flush) begin
          drop_d = 1'b1;
        end
      end

      StResp: begin
        if (asm_done) begin
          state_d = ext_flush ? StIdle : StFill;
        end else if (ext_flush) begin
          state_d = StDrain;
        end
      end

      StFill: begin
        pend_addr_d[0] = pend_addr_q[1];
        pend_cnt_d     = pend_cnt_q - 2'd1;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        pf_head_d = 1'b0;
        if (!ff_vld_q) begin
          ff_vld_d  = 1'b1;
          ff_addr_d = pend_addr_q[0];
        end
`endif
        if (ext_flush) begin
          state_d = StIdle;
        end else if (pend_cnt_q == 2'd2) begin
          state_d = StReq;
        end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        else if (!pf_head_q && !(ff_vld_q && (ff_addr_q == pf_line))) begin
          pend_addr_d[0] = pf_line;
          pend_cnt_d     = 2'd1;
          pf_head_d      = 1'b1;
          state_d        = StReq;
        end
`endif
        else begin
          wait_cnt_d = 1'b0;
          state_d    = StWait;
        end
      end

      StWait: begin
        // Two quiet cycles so the cache's registered miss can clear.
        if (ext_flush || wait_cnt_q) begin
          state_d = StIdle;
        end else begin
          wait_cnt_d = 1'b1;
        end
      end

      StDrain: begin
        if (asm_done) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (ext_flush) begin
      pend_cnt_d = 2'd0;
    end

    req_valid_d  = (state_d == StReq);
    if ((state_d == StReq) && (state_q != StReq)) begin
      req_addr_d = pend_addr_d[0];
    end
    fill_valid_d = (state_d == StFill);
    if (state_d == StFill) begin
      fill_addr_d = pend_addr_q[0];
    end
    busy_d       = (state_d != StIdle);
  end

  // State, pending list and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      pend_addr_q[0] <= '0;
      pend_addr_q[1] <= '0;
      pend_cnt_q     <= 2'd0;
      drop_q         <= 1'b0;
      wait_cnt_q     <= 1'b0;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      fill_valid_q   <= 1'b0;
      fill_addr_q    <= '0;
      busy_q         <= 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      pf_head_q      <= 1'b0;
      ff_vld_q       <= 1'b0;
      ff_addr_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pend_addr_q[0] <= pend_addr_d[0];
      pend_addr_q[1] <= pend_addr_d[1];
      pend_cnt_q     <= pend_cnt_d;
      drop_q         <= drop_d;
      wait_cnt_q     <= wait_cnt_d;
      req_valid_q    <= req_valid_d;
      req_addr_q     <= req_addr_d;
      fill_valid_q   <= fill_valid_d;
      fill_addr_q    <= fill_addr_d;
      busy_q         <= busy_d;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
      pf_head_q      <= pf_head_d;
      ff_vld_q       <= ff_vld_d;
      ff_addr_q      <= ff_addr_d;
`endif
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign fill_valid    = fill_valid_q;
  assign fill_addr     = fill_addr_q;
  assign fill_data     = asm_line;
  assign busy          = busy_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized miss episodes against a transaction-level model of
// the refill sequencer (expected request list, fill contents and cycle relations).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_icache_refill_ctrl;

  localparam int unsigned LS = 2;
  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned LB = 4 * LS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        miss = '0;
  logic [AW-1:0]     miss_addr [2];
  logic              ext_flush = 1'b0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_resp_valid = 1'b0;
  logic [31:0]       mem_resp_data = '0;
  logic              fill_valid;
  logic [AW-1:0]     fill_addr;
  logic [32*LS-1:0]  fill_data;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .LINE_SIZE(LS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .miss          (miss),
    .miss_addr     (miss_addr),
    .ext_flush     (ext_flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .fill_valid    (fill_valid),
    .fill_addr     (fill_addr),
    .fill_data     (fill_data),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~(AW'(LB - 1));
  endfunction

  // fkind: 0 plain, 1 flush after first beat, 2 flush while request stalled,
  //        3 flush together with the miss in IDLE, then a normal miss.
  // bp >= 0: deterministic ready after bp low cycles and back-to-back beats; -1: random.
  task automatic episode(input logic [1:0] m, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input int bp, input int fkind);
    logic [AW-1:0]    exp_q[$];
    logic [AW-1:0]    cur_line, hold_addr;
    logic [32*LS-1:0] cur_data;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    logic [AW-1:0]    pf;
`endif
    int nreq, nfill, miss_cyc, hs_cyc, last_beat, last_fill, beats_left, bi, bp_left;
    int exp_fills, budget;
    bit hold_pend, prev_rv, flushed, flush_next, flush_now, done, hs, flush_ep;

    nreq = 0; nfill = 0; hs_cyc = -1; last_beat = -1; last_fill = -1;
    beats_left = 0; bi = 0; budget = 0;
    bp_left = (bp > 0) ? bp : 0;
    hold_pend = 0; prev_rv = 0; flushed = 0; flush_next = 0; done = 0;
    cur_line = '0; hold_addr = '0; cur_data = '0;
    flush_ep = (fkind == 1) || (fkind == 2);

    if (m[0]) exp_q.push_back(align(a0));
    if (m[1] && !(m[0] && (align(a1) == align(a0)))) exp_q.push_back(align(a1));
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    pf = exp_q[exp_q.size()-1] + AW'(LB);
    if (!((exp_q.size() == 2) && (pf == exp_q[0]))) exp_q.push_back(pf);
`endif
    exp_fills = flush_ep ? 0 : exp_q.size();

    miss_addr[0] = a0;
    miss_addr[1] = a1;
    if (fkind == 3) begin
      miss = m;
      ext_flush = 1'b1;
      tick();
      ext_flush = 1'b0;
      check("flush_wins_busy", busy, 1'b0);
      check("flush_wins_req", mem_req_valid, 1'b0);
    end
    miss = m;
    miss_cyc = cyc;

    while (!done && budget < 300) begin
      budget++;
      flush_now = flush_next;
      flush_next = 0;
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (bp_left > 0) bp_left--;
        else mem_req_ready = (bp >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (fkind == 2 && nreq == 0 && !flushed) begin
          flush_now = 1;
          mem_req_ready = 1'b0;
          bp_left = 2;
        end
      end
      if (flush_now) begin
        flushed = 1;
        miss = '0;
      end
      ext_flush = flush_now;
      hs = mem_req_valid && mem_req_ready;
      hold_pend = mem_req_valid && !mem_req_ready;
      if (hold_pend) hold_addr = (nreq < exp_q.size()) ? exp_q[nreq] : '0;
      if (hs) begin
        if (nreq < exp_q.size()) begin
          check("req_addr", mem_req_addr, exp_q[nreq]);
          cur_line = exp_q[nreq];
        end else begin
          check("req_count_over", nreq + 1, exp_q.size());
        end
        if (nreq == 0 && bp >= 0 && fkind != 2) check("hs_cycle", cyc, miss_cyc + 1 + bp);
        nreq++;
        beats_left = LS;
        bi = 0;
        hs_cyc = cyc;
      end
      mem_resp_valid = 1'b0;
      if (beats_left > 0 && cyc > hs_cyc && !flush_now &&
          (bp >= 0 || $urandom_range(0, 2) != 0)) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = (bp >= 0) ? ((bi == 0) ? 32'hAAAA0000 : 32'hBBBB1111) : $urandom;
        cur_data[32*bi +: 32] = mem_resp_data;
        bi++;
        beats_left--;
        if (beats_left == 0) last_beat = cyc;
        if (fkind == 1 && nreq == 1 && bi == 1 && !flushed) flush_next = 1;
      end else begin
        mem_resp_data = $urandom;
      end

      tick();

      if (hold_pend) begin
        check("req_hold_valid", mem_req_valid, 1'b1);
        check("req_hold_addr", mem_req_addr, hold_addr);
      end
      if (mem_req_valid && !prev_rv) begin
        if (nreq == 0) check("req_latency", cyc, miss_cyc + 1);
        else check("req_after_fill", cyc, last_fill + 1);
      end
      prev_rv = mem_req_valid;
      if (fill_valid) begin
        check("fill_time", cyc, last_beat + 1);
        check("fill_addr", fill_addr, cur_line);
        check("fill_data", fill_data, cur_data);
        nfill++;
        last_fill = cyc;
      end
      if (!flush_ep && nfill == exp_fills && last_fill >= 0) begin
        if (cyc < last_fill + 3) begin
          check("wait_busy", busy, 1'b1);
        end else begin
          check("wait_end", busy, 1'b0);
          done = 1;
        end
      end
      if (flush_ep && flushed && beats_left == 0 && last_beat >= 0) begin
        if (cyc == last_beat) check("drain_busy", busy, 1'b1);
        if (cyc == last_beat + 1) begin
          check("drain_end", busy, 1'b0);
          done = 1;
        end
      end
    end

    check("episode_done", done, 1'b1);
    check("req_count", nreq, flush_ep ? 1 : exp_q.size());
    check("fill_count", nfill, exp_fills);
    miss = '0;
    ext_flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0]    m;
    logic [AW-1:0] a0, a1;
    int            fk, r;

    miss_addr[0] = '0;
    miss_addr[1] = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, '0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_fill_addr", fill_addr, '0);
    check("rst_fill_data", fill_data, '0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    episode(2'b01, 32'h0000_1004, 32'h0, 0, 0);
    episode(2'b11, 32'h0000_2000, 32'h0000_3008, 0, 0);
    episode(2'b11, 32'h0000_4000, 32'h0000_4004, 0, 0);
    episode(2'b01, 32'h0000_6000, 32'h0, 5, 0);
    episode(2'b11, 32'h0000_2000, 32'h0000_3008, 0, 1);
    episode(2'b01, 32'h0000_5000, 32'h0, 0, 0);
    episode(2'b10, 32'h0, 32'h0000_8010, 0, 2);
    episode(2'b11, 32'h0000_9008, 32'h0000_9000, 0, 3);

    for (int i = 0; i < 40; i++) begin
      m  = 2'($urandom_range(1, 3));
      a0 = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 2) a1 = align(a0) | AW'($urandom_range(0, LB - 1));
      else if (r < 4) a1 = align(a0) - AW'(LB);
      else a1 = $urandom;
      r  = $urandom_range(0, 9);
      fk = (r < 6) ? 0 : (r - 6);
      episode(m, a0, a1, -1, fk);
    end

    // Reset in the middle of a refill, then late beats must be ignored.
    miss_addr[0] = 32'h0000_7000;
    miss = 2'b01;
    tick();
    miss = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hDEAD_BEEF;
    tick();
    check("midrst_req_valid", mem_req_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_fill_data", fill_data, '0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("late_beat_fill", fill_valid, 1'b0);
      check("late_beat_busy", busy, 1'b0);
    end
    mem_resp_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
